control_seq: RTL
================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high; clock clk.
REQ-003 SHALL provide: run  input  1  sampled in FETCH; 0 = stall before next fetch.
REQ-004 SHALL provide: bus_in  input  8  shared data bus, carrying the instruction byte in FETCH.
REQ-005 SHALL provide: regaddr  output  4  register-file address, equal to IR[3:0].
REQ-006 SHALL provide: c_regwrite  output  1  register file captures bus this cycle.
REQ-007 SHALL provide: c_regread  output  1  register file drives bus this cycle.
REQ-008 SHALL provide: c_memread, c_pcinc  output  1 each  memory drives bus; PC increments at the end of the cycle.
REQ-009 SHALL provide: c_accload, c_accread  output  1 each  ACC captures bus; ACC drives bus.
REQ-010 SHALL provide: halted, illegal_op  output  1 each  in HALT state; one-cycle pulse on an undefined opcode.
REQ-011 SHALL provide: instr_count  output  8  count of retired instructions.

Function
REQ-012 SHALL hold an 8-bit IR; opcode = IR[7:4]; register field = IR[3:0].
REQ-013 SHALL implement states FETCH, DECODE, EXEC, HALT; one state per clock.
REQ-014 FETCH with run=1: assert c_memread and c_pcinc; IR <= bus_in; next state DECODE.
REQ-015 FETCH with run=0: assert no strobes; IR unchanged; stay in FETCH.
REQ-016 DECODE: assert no strobes; register regaddr <= IR[3:0]; next state EXEC.
REQ-017 EXEC, opcode 0x0 NOP: no strobes.
REQ-018 EXEC, opcode 0x1 LDI: assert c_memread, c_regwrite and c_pcinc (immediate byte -> Rn).
REQ-019 EXEC, opcode 0x2 LDA: assert c_regread and c_accload (Rn -> ACC).
REQ-020 EXEC, opcode 0x3 STA: assert c_accread and c_regwrite (ACC -> Rn).
REQ-021 EXEC, opcode 0xF HLT: no strobes; next state HALT.
REQ-022 EXEC, opcode 0x4-0xE: pulse illegal_op for exactly that cycle; otherwise behave as NOP.
REQ-023 From EXEC, every opcode other than HLT SHALL go to FETCH, giving 3 cycles per instruction.
REQ-024 instr_count SHALL increment by 1 on every EXEC cycle, including HLT and illegal opcodes, wrapping 0xFF -> 0x00.
REQ-025 HALT: halted=1, all strobes 0, state held until reset; run is ignored.
REQ-026 At most one of c_memread, c_regread, c_accread SHALL be 1 in any cycle.
REQ-027 All strobes SHALL be decoded from registered state and IR only, with no combinational path from bus_in.
REQ-028 regaddr SHALL be stable from DECODE through EXEC and change only in DECODE.

Reset
REQ-029 reset=1 SHALL force on the next edge: state FETCH, IR=0x00, regaddr=0, instr_count=0.
REQ-030 While reset=1, all strobes, halted and illegal_op SHALL be 0.
REQ-031 Reset SHALL take priority over run and over any in-progress instruction, including mid-EXEC and HALT; the aborted instruction SHALL have no further strobes.
REQ-032 On the first edge after reset is released, with run=1, FETCH SHALL be executed.

Structure
REQ-033 Opcode constants (NOP, LDI, LDA, STA, HLT) and state encodings SHALL live in the shared CPU package for reuse by the assembler and test benches.
REQ-034 A single sub-module, op_decode, SHALL be combinational and map (state, opcode) to the strobe vector; the FSM, IR and counter SHALL remain in control_seq.

Verification
REQ-035 Reset, then run=1 with bus 0x15, then 0xA7 -> LDI cycle shows regaddr=5 with c_memread, c_regwrite and c_pcinc all 1; instr_count=1.
REQ-036 Stream 0x15, 0xA7, 0x25, 0x33 -> LDA asserts c_regread and c_accload with regaddr=5; STA asserts c_accread and c_regwrite with regaddr=3; instr_count=3.
REQ-037 Instruction 0x70 -> illegal_op high for exactly the EXEC cycle; then FETCH; no strobes during that EXEC.
REQ-038 Instruction 0xF0 -> halted=1 from the cycle after EXEC; strobes stay 0 for 20 cycles with run toggling; reset returns to FETCH with halted=0.
REQ-039 run=0 held for 5 cycles in FETCH -> no strobes and IR unchanged; run=1 -> fetch on the next edge.
REQ-040 256 NOPs -> instr_count wraps to 0x00; reset asserted mid-EXEC of an LDI -> next cycle has all strobes 0 and instr_count=0; the bus-driver exclusivity assertion holds throughout.

Source files
------------

// File: rtl/control_seq_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants, sequencer
// state encoding and the control-strobe bundle produced by the decoder.
package control_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_LDA = 4'h2;
  localparam logic [OP_W-1:0] OP_STA = 4'h3;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic memread;
    logic pcinc;
    logic regwrite;
    logic regread;
    logic accload;
    logic accread;
    logic illegal_op;
    logic halted;
  } strobe_t;

endpackage

// File: rtl/control_seq_op_decode.sv
// op_decode: combinational map of (state, opcode, run) to the strobe bundle.
// Ports:
//   state   in  current sequencer state
//   opcode  in  IR[7:4]
//   run     in  fetch enable, only meaningful in FETCH
//   strobes out strobe bundle for this cycle
module op_decode
  import control_seq_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            run,
  output strobe_t         strobes
);

  always_comb begin
    strobes = '0;
    case (state)
      ST_FETCH: begin
        strobes.memread = run;
        strobes.pcinc   = run;
      end
      ST_DECODE: ;
      ST_EXEC: begin
        case (opcode)
          OP_NOP, OP_HLT: ;
          OP_LDI: begin
            strobes.memread  = 1'b1;
            strobes.regwrite = 1'b1;
            strobes.pcinc    = 1'b1;
          end
          OP_LDA: begin
            strobes.regread = 1'b1;
            strobes.accload = 1'b1;
          end
          OP_STA: begin
            strobes.accread  = 1'b1;
            strobes.regwrite = 1'b1;
          end
          default: strobes.illegal_op = 1'b1;
        endcase
      end
      ST_HALT: strobes.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: 3-cycle FETCH/DECODE/EXEC control sequencer with HALT.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   run                 fetch enable (sampled in FETCH)
//   bus_in[7:0]         data bus, instruction byte in FETCH
//   regaddr[3:0]        register address (registered in DECODE)
//   c_regwrite/regread  register file capture / drive
//   c_memread, c_pcinc  memory drive / PC increment
//   c_accload/accread   accumulator capture / drive
//   halted, illegal_op  HALT state, undefined-opcode pulse in EXEC
//   instr_count[7:0]    retired instruction count (wraps)
module control_seq
  import control_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] bus_in,
  output logic [REG_W-1:0]  regaddr,
  output logic              c_regwrite,
  output logic              c_regread,
  output logic              c_memread,
  output logic              c_pcinc,
  output logic              c_accload,
  output logic              c_accread,
  output logic              halted,
  output logic              illegal_op,
  output logic [DATA_W-1:0] instr_count
);

  state_t            state;
  logic [DATA_W-1:0] ir;
  strobe_t           dec;
  strobe_t           gated;

  op_decode u_op_decode (
    .state   (state),
    .opcode  (ir[DATA_W-1:REG_W]),
    .run     (run),
    .strobes (dec)
  );

  // Strobes come only from state/IR (plus run in FETCH); reset silences them
  // immediately so an aborted instruction drives nothing further.
  assign gated      = reset ? strobe_t'('0) : dec;
  assign c_memread  = gated.memread;
  assign c_pcinc    = gated.pcinc;
  assign c_regwrite = gated.regwrite;
  assign c_regread  = gated.regread;
  assign c_accload  = gated.accload;
  assign c_accread  = gated.accread;
  assign illegal_op = gated.illegal_op;
  assign halted     = gated.halted;

  // Sequencer state, instruction register, register address and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      ir          <= '0;
      regaddr     <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run) begin
            ir    <= bus_in;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          regaddr <= ir[REG_W-1:0];
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          instr_count <= DATA_W'(instr_count + DATA_W'(1));
          state       <= (ir[DATA_W-1:REG_W] == OP_HLT) ? ST_HALT : ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
